// File: rtl/demux_vc_pkg.sv
// Shared constants and helpers for the virtual-channel demux.
// Optional per-channel delivery counters are enabled with DEMUX_VC_CNT_EN.
package demux_vc_pkg;

  localparam int DEF_DATA_W  = 6;
  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_SEL_LSB = 4;
  localparam int CNT_W       = 8;

  function automatic int ch_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/demux_vc_hold.sv
// One-entry hold register for a word whose target channel was full.
// Load and release are never requested in the same cycle by the top.
module demux_vc_hold
  import demux_vc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              load_i,
  input  logic              rel_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CH_W-1:0]   ch_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CH_W-1:0]   ch_o
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ch_d   = ch_q;
    if (rel_i) vld_d = 1'b0;
    if (load_i) begin
      vld_d  = 1'b1;
      data_d = data_i;
      ch_d   = ch_i;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ch_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ch_q   <= ch_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign ch_o   = ch_q;

endmodule

// File: rtl/demux_vc_n.sv
// Demux of one word stream onto NUM_CH virtual channels with full-backpressure.
// Define DEMUX_VC_CNT_EN to add per-channel 8-bit delivery counters on cnt_out.
module demux_vc_n
  import demux_vc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int SEL_LSB = DEF_SEL_LSB
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     valid_in,
  input  logic [NUM_CH-1:0]        full_in,
  output logic                     ready_out,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out
`ifdef DEMUX_VC_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]  cnt_out
`endif
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [CH_W-1:0]   sel_ch;
  logic              hold_vld;
  logic [DATA_W-1:0] hold_data;
  logic [CH_W-1:0]   hold_ch;
  logic              accept, load, rel, dlv;
  logic [CH_W-1:0]   dlv_ch;
  logic [DATA_W-1:0] dlv_data;

  logic [NUM_CH-1:0]        valid_out_q, valid_out_d;
  logic [NUM_CH*DATA_W-1:0] data_out_q, data_out_d;

  assign sel_ch    = data_in[SEL_LSB +: CH_W];
  assign ready_out = ~hold_vld;
  assign accept    = valid_in & ready_out;
  assign load      = accept & full_in[sel_ch];
  assign rel       = hold_vld & ~full_in[hold_ch];
  assign dlv       = rel | (accept & ~full_in[sel_ch]);
  assign dlv_ch    = rel ? hold_ch : sel_ch;
  assign dlv_data  = rel ? hold_data : data_in;

  demux_vc_hold #(
    .DATA_W (DATA_W),
    .CH_W   (CH_W)
  ) u_hold (
    .clk     (clk),
    .reset_L (reset_L),
    .load_i  (load),
    .rel_i   (rel),
    .data_i  (data_in),
    .ch_i    (sel_ch),
    .vld_o   (hold_vld),
    .data_o  (hold_data),
    .ch_o    (hold_ch)
  );

  always_comb begin
    valid_out_d = '0;
    data_out_d  = data_out_q;
    if (dlv) begin
      valid_out_d[dlv_ch] = 1'b1;
      data_out_d[dlv_ch*DATA_W +: DATA_W] = dlv_data;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid_out_q <= '0;
      data_out_q  <= '0;
    end else begin
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

`ifdef DEMUX_VC_CNT_EN
  logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;

  // Counters wrap naturally at 2**CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (dlv) begin
      cnt_d[dlv_ch*CNT_W +: CNT_W] = cnt_q[dlv_ch*CNT_W +: CNT_W] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_demux_vc_n.sv
// Directed self-checking bench for demux_vc_n (DATA_W=6, NUM_CH=4, SEL_LSB=4).
// Counter checks are compiled in when DEMUX_VC_CNT_EN is defined.
module tb_demux_vc_n;

  logic        clk;
  logic        reset_L;
  logic [5:0]  data_in;
  logic        valid_in;
  logic [3:0]  full_in;
  logic        ready_out;
  logic [23:0] data_out;
  logic [3:0]  valid_out;
`ifdef DEMUX_VC_CNT_EN
  logic [31:0] cnt_out;
`endif

  int total;
  int bad;

  demux_vc_n #(
    .DATA_W  (6),
    .NUM_CH  (4),
    .SEL_LSB (4)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .full_in   (full_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out)
`ifdef DEMUX_VC_CNT_EN
    ,
    .cnt_out   (cnt_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vin;
    logic [5:0]  din;
    logic [3:0]  full;
    logic        rdy;
    logic [3:0]  vout;
    logic [23:0] dout;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    full_in  = '0;

    tv[0]  = '{1'b1, 6'h11, 4'b0000, 1'b1, 4'b0010, 24'h000440};
    tv[1]  = '{1'b1, 6'h32, 4'b0000, 1'b1, 4'b1000, 24'hC80440};
    tv[2]  = '{1'b1, 6'h33, 4'b0000, 1'b1, 4'b1000, 24'hCC0440};
    tv[3]  = '{1'b1, 6'h14, 4'b0000, 1'b1, 4'b0010, 24'hCC0500};
    tv[4]  = '{1'b0, 6'h00, 4'b0000, 1'b1, 4'b0000, 24'hCC0500};
    tv[5]  = '{1'b1, 6'h32, 4'b1000, 1'b1, 4'b0000, 24'hCC0500};
    tv[6]  = '{1'b1, 6'h14, 4'b1000, 1'b0, 4'b0000, 24'hCC0500};
    tv[7]  = '{1'b1, 6'h14, 4'b1000, 1'b0, 4'b0000, 24'hCC0500};
    tv[8]  = '{1'b1, 6'h14, 4'b1000, 1'b0, 4'b0000, 24'hCC0500};
    tv[9]  = '{1'b1, 6'h14, 4'b0000, 1'b0, 4'b1000, 24'hC80500};
    tv[10] = '{1'b1, 6'h14, 4'b0000, 1'b1, 4'b0010, 24'hC80500};
    tv[11] = '{1'b1, 6'h11, 4'b0100, 1'b1, 4'b0010, 24'hC80440};
    tv[12] = '{1'b0, 6'h00, 4'b0100, 1'b1, 4'b0000, 24'hC80440};
    tv[13] = '{1'b1, 6'h05, 4'b0001, 1'b1, 4'b0000, 24'hC80440};
    tv[14] = '{1'b0, 6'h00, 4'b1110, 1'b0, 4'b0001, 24'hC80445};
    tv[15] = '{1'b0, 6'h00, 4'b0000, 1'b1, 4'b0000, 24'hC80445};

    #1;
    chk("rst_vout", {28'd0, valid_out}, 32'd0);
    chk("rst_dout", {8'd0, data_out}, 32'd0);
    chk("rst_rdy", {31'd0, ready_out}, 32'd1);
    #11 reset_L = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      valid_in = tv[i].vin;
      data_in  = tv[i].din;
      full_in  = tv[i].full;
      #1;
      chk($sformatf("v%0d_rdy", i), {31'd0, ready_out}, {31'd0, tv[i].rdy});
      tick();
      chk($sformatf("v%0d_vout", i), {28'd0, valid_out}, {28'd0, tv[i].vout});
      chk($sformatf("v%0d_dout", i), {8'd0, data_out}, {8'd0, tv[i].dout});
    end

    // Mid-cycle asynchronous reset with a live strobe on the outputs.
    valid_in = 1'b1;
    data_in  = 6'h21;
    full_in  = 4'b0000;
    tick();
    chk("pre_rst_vout", {28'd0, valid_out}, 32'h4);
    valid_in = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    chk("arst_vout", {28'd0, valid_out}, 32'd0);
    chk("arst_dout", {8'd0, data_out}, 32'd0);
    chk("arst_rdy", {31'd0, ready_out}, 32'd1);
    tick();
    reset_L = 1'b1;

    // Reset while holding: held word must be discarded.
    valid_in = 1'b1;
    data_in  = 6'h32;
    full_in  = 4'b1000;
    tick();
    valid_in = 1'b0;
    chk("mh_rdy0", {31'd0, ready_out}, 32'd0);
    chk("mh_vout0", {28'd0, valid_out}, 32'd0);
    #2 reset_L = 1'b0;
    #1;
    chk("mh_rdy_rst", {31'd0, ready_out}, 32'd1);
    tick();
    reset_L = 1'b1;
    full_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mh_vout%0d", i), {28'd0, valid_out}, 32'd0);
      chk($sformatf("mh_dout%0d", i), {8'd0, data_out}, 32'd0);
      chk($sformatf("mh_rdy%0d", i), {31'd0, ready_out}, 32'd1);
    end

    // First acceptance right after reset release.
    valid_in = 1'b1;
    data_in  = 6'h07;
    tick();
    valid_in = 1'b0;
    chk("post_rst_vout", {28'd0, valid_out}, 32'h1);
    chk("post_rst_dout", {8'd0, data_out}, 32'h000007);

`ifdef DEMUX_VC_CNT_EN
    reset_L = 1'b0;
    #1;
    chk("cnt_rst", cnt_out, 32'd0);
    tick();
    reset_L  = 1'b1;
    valid_in = 1'b1;
    data_in  = 6'h20;
    full_in  = 4'b0000;
    for (int i = 0; i < 255; i++) tick();
    chk("cnt_255", {24'd0, cnt_out[23:16]}, 32'd255);
    chk("cnt_oth255", {cnt_out[31:24], 8'd0, cnt_out[15:0]}, 32'd0);
    tick();
    valid_in = 1'b0;
    chk("cnt_wrap", {24'd0, cnt_out[23:16]}, 32'd0);
    chk("cnt_oth256", {cnt_out[31:24], 8'd0, cnt_out[15:0]}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
